alu_seq: RTL

//  Parametrised multi-cycle successor of the 8-bit CPU ALU, for widened datapaths (8/16/24/32-bit).

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_addsub.sv | 33 +++
 rtl/alu_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Op codes and FSM state encoding shared by the sequential ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] OP_ADC  = 3'b000;
    localparam logic [2:0] OP_SBC  = 3'b001;
    localparam logic [2:0] OP_ROL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_MULU = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_ADCD = 3'b110;
    localparam logic [2:0] OP_SBCD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_addsub
//  Purpose  : Combinational adder with optional B inversion, carry and
//             signed-overflow outputs.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_addsub
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_total;

    assign w_b     = sub ? ~b : b;
    assign w_total = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, cin};
    assign sum     = w_total[WIDTH-1:0];
    assign cout    = w_total[WIDTH];
    // Overflow is judged on the operand actually fed to the adder (inverted for subtract).
    assign ovf     = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Multi-cycle ALU: add/sub/rotate, shift-add multiply, restoring
//             divide and nibble-serial BCD add/sub with start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int              CNTW      = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] c_cnt_bin = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] c_cnt_bcd = CNTW'(WIDTH / 4);
    localparam logic [CNTW-1:0] c_cnt_one = CNTW'(1);

    state_t           r_state;
    logic [2:0]       r_op;
    logic             r_cin;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_acc;
    logic [CNTW-1:0]  r_cnt;
    logic             r_carry;
    logic             r_bcd_v;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_c;
    logic             r_z;
    logic             r_n;
    logic             r_v;

    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_sub;
    logic             w_add_cin;
    logic [WIDTH-1:0] w_add_sum;
    logic             w_add_cout;
    logic             w_add_ovf;
    logic             w_div_ge;

    logic             w_nib_sub;
    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;
    logic             w_nib_ovf;
    logic [3:0]       w_nib_digit;
    logic             w_nib_dc;

    logic [CNTW-1:0]  w_start_cnt;
    logic [WIDTH-1:0] w_fin_res;
    logic [WIDTH-1:0] w_fin_hi;
    logic             w_fin_c;
    logic             w_fin_v;

    // Wide adder is time-shared: ADC/SBC final, MULU partial sum, DIVU trial subtract.
    always_comb begin
        w_add_a   = r_opa;
        w_add_b   = r_opb;
        w_add_sub = 1'b0;
        w_add_cin = r_cin;
        case (r_op)
            OP_SBC: w_add_sub = 1'b1;
            OP_MULU: begin
                w_add_a   = r_hi;
                w_add_b   = r_opa;
                w_add_cin = 1'b0;
            end
            OP_DIVU: begin
                w_add_a   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                w_add_b   = r_opb;
                w_add_sub = 1'b1;
                w_add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    alu_seq_addsub #(.WIDTH(WIDTH)) u_add_wide (
        .a    (w_add_a),
        .b    (w_add_b),
        .sub  (w_add_sub),
        .cin  (w_add_cin),
        .sum  (w_add_sum),
        .cout (w_add_cout),
        .ovf  (w_add_ovf)
    );

    // The shifted partial remainder is WIDTH+1 bits; a set top bit guarantees it exceeds b.
    assign w_div_ge  = w_add_cout | r_hi[WIDTH-1];

    assign w_nib_sub = (r_op == OP_SBCD);

    alu_seq_addsub #(.WIDTH(4)) u_add_nib (
        .a    (r_lo[3:0]),
        .b    (r_hi[3:0]),
        .sub  (w_nib_sub),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout),
        .ovf  (w_nib_ovf)
    );

    always_comb begin
        w_nib_dc    = 1'b0;
        w_nib_digit = w_nib_sum;
        if (w_nib_sub) begin
            w_nib_dc    = w_nib_cout;
            w_nib_digit = w_nib_cout ? w_nib_sum : (w_nib_sum - 4'd6);
        end else begin
            w_nib_dc    = w_nib_cout | (w_nib_sum > 4'd9);
            w_nib_digit = w_nib_dc ? (w_nib_sum + 4'd6) : w_nib_sum;
        end
    end

    always_comb begin
        w_start_cnt = '0;
        case (op)
            OP_MULU:          w_start_cnt = c_cnt_bin;
            OP_DIVU:          w_start_cnt = (b == '0) ? '0 : c_cnt_bin;
            OP_ADCD, OP_SBCD: w_start_cnt = c_cnt_bcd;
            default:          w_start_cnt = '0;
        endcase
    end

    always_comb begin
        w_fin_res = '0;
        w_fin_hi  = '0;
        w_fin_c   = 1'b0;
        w_fin_v   = 1'b0;
        case (r_op)
            OP_ADC, OP_SBC: begin
                w_fin_res = w_add_sum;
                w_fin_c   = w_add_cout;
                w_fin_v   = w_add_ovf;
            end
            OP_ROL: begin
                w_fin_res = {r_opa[WIDTH-2:0], r_cin};
                w_fin_c   = r_opa[WIDTH-1];
            end
            OP_ROR: begin
                w_fin_res = {r_cin, r_opa[WIDTH-1:1]};
                w_fin_c   = r_opa[0];
            end
            OP_MULU: begin
                w_fin_res = r_lo;
                w_fin_hi  = r_hi;
                w_fin_c   = |r_hi;
            end
            OP_DIVU: begin
                if (r_opb == '0) begin
                    w_fin_res = '1;
                    w_fin_hi  = r_opa;
                    w_fin_v   = 1'b1;
                end else begin
                    w_fin_res = r_lo;
                    w_fin_hi  = r_hi;
                end
            end
            default: begin
                w_fin_res = r_acc;
                w_fin_c   = r_carry;
                w_fin_v   = r_bcd_v;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADC;
            r_cin       <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_bcd_v     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                        case (r_op)
                            OP_MULU: begin
                                if (r_lo[0]) begin
                                    r_hi <= {w_add_cout, w_add_sum[WIDTH-1:1]};
                                    r_lo <= {w_add_sum[0], r_lo[WIDTH-1:1]};
                                end else begin
                                    r_hi <= {1'b0, r_hi[WIDTH-1:1]};
                                    r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
                                end
                            end
                            OP_DIVU: begin
                                r_hi <= w_div_ge ? w_add_sum : w_add_a;
                                r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
                            end
                            default: begin
                                // BCD digits enter the accumulator from the top, LSB digit first.
                                r_lo    <= {4'b0000, r_lo[WIDTH-1:4]};
                                r_hi    <= {4'b0000, r_hi[WIDTH-1:4]};
                                r_acc   <= {w_nib_digit, r_acc[WIDTH-1:4]};
                                r_carry <= w_nib_dc;
                                r_bcd_v <= w_nib_ovf;
                            end
                        endcase
                    end else begin
                        r_state     <= S_FIN;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_result    <= w_fin_res;
                        r_result_hi <= w_fin_hi;
                        r_c         <= w_fin_c;
                        r_v         <= w_fin_v;
                        r_z         <= (w_fin_res == '0);
                        r_n         <= w_fin_res[WIDTH-1];
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= op;
                        r_cin   <= c_in;
                        r_opa   <= a;
                        r_opb   <= b;
                        r_hi    <= (op == OP_ADCD || op == OP_SBCD) ? b : '0;
                        r_lo    <= (op == OP_MULU) ? b : a;
                        r_acc   <= '0;
                        r_cnt   <= w_start_cnt;
                        r_carry <= c_in;
                        r_bcd_v <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flag_c    = r_c;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_v    = r_v;

endmodule
`default_nettype wire
